multu_unit: RTL and testbench
=============================

Name: multu_unit

Overview:
Sequential unsigned multiplier with HI/LO registers. It executes the MIPS multu, mfhi and mflo operations selected by the 6-bit SIG_MULTIPLIER function code from the ALU control unit. It sits beside the ALU in the single-cycle datapath. While a multiply is in progress it raises a stall so the datapath can hold the instruction; the mfhi/mflo result feeds the register write-back mux.

Parameters:
WIDTH, 32, operand width; HI and LO are each WIDTH bits and the product is 2*WIDTH bits.
F_MULTU, 6'd25, function code that starts an unsigned multiply.
F_MFHI, 6'd16, function code that reads HI.
F_MFLO, 6'd18, function code that reads LO.

Ports:
clk  input  1  rising-edge clock; the only clock.
rst  input  1  synchronous, active-high reset.
SIG_MULTIPLIER  input  6  function code from the ALU control unit; any other value means no operation.
dataA  input  WIDTH  multiplicand (rs value).
dataB  input  WIDTH  multiplier (rt value).
dataOut  output  WIDTH  HI on F_MFHI, LO on F_MFLO, otherwise 0.
busy  output  1  high while a multiply is running.
done  output  1  one-cycle pulse when HI/LO have just been updated.
stall  output  1  request to the datapath to hold the current instruction.

Behaviour:
- Reset is synchronous and active-high and applies on any clk edge with rst=1, including mid-multiply. On reset:
  - state=IDLE, count=0, HI=0, LO=0, internal product and operand registers cleared.
  - busy=0, done=0, stall=0, dataOut=0.
- States:
  - IDLE: waiting for a command.
  - RUN: 32 iterations (WIDTH iterations in general).
  - DONE: one-cycle completion state.
- IDLE -> RUN: on a clk edge with SIG_MULTIPLIER==F_MULTU.
  - Latch mcand = {WIDTH'b0, dataA} (2*WIDTH bits) and mplier = dataB.
  - Clear prod, set count=0.
- RUN, each edge:
  - If mplier[0]=1, prod <= prod + mcand, computed modulo 2^(2*WIDTH); it cannot overflow for unsigned operands.
  - Then mcand <<= 1, mplier >>= 1, count <= count+1.
  - On the edge where count==WIDTH-1, the final accumulate is written straight into {HI,LO}, and the state moves to DONE.
- DONE: done=1 for exactly one cycle; next edge returns to IDLE unconditionally.
- Latency:
  - multu accepted at edge 0; RUN edges 1..32.
  - HI/LO valid after edge 32; done is high during the cycle after edge 32.
  - A new multu is accepted at the earliest on edge 34.
- busy = (state==RUN) || (state==DONE).
- stall = busy && (SIG_MULTIPLIER is F_MULTU, F_MFHI or F_MFLO).
  - A stalled command is not executed and not queued; the datapath re-presents it.
  - A multu presented in DONE is therefore accepted on the edge after DONE.
- dataOut is combinational from SIG_MULTIPLIER, HI and LO:
  - While stalled it shows the old HI/LO; it is only meaningful when stall=0.
  - mfhi/mflo in IDLE read the current registers with no latency.
- Operands are sampled only on the accepting edge; changes to dataA/dataB during RUN have no effect.
- Unknown or illegal codes (including F_MULTU while busy) never change HI/LO.
- Zero operands still take the full 32 iterations; there is no early termination.

Decomposition:
- Shared package mips_funct_pkg holds:
  - funct constants F_ADD, F_SUB, F_AND, F_OR, F_SLT, F_SLL, F_MULTU, F_MFHI, F_MFLO;
  - ALU operation constants;
  - the multiplier state encoding (IDLE=2'b00, RUN=2'b01, DONE=2'b10).
- The ALU control unit and multu_unit both import this package.
- No sub-module: the datapath and FSM are small enough for a single module. The HI/LO pair is plain registers, not a separate block.

Test Plan:
- Reset, then multu dataA=3, dataB=5 → busy=1 for 33 cycles, done pulses once after edge 32; then mfhi→dataOut=0x00000000, mflo→dataOut=0x0000000F.
- multu 0xFFFFFFFF × 0xFFFFFFFF → HI=0xFFFFFFFE, LO=0x00000001; multu 0x80000000 × 2 → HI=0x00000001, LO=0x00000000.
- Present mfhi at cycle 5 of a RUN with prior HI=0x12345678 → stall=1, dataOut=0x12345678, HI unchanged until edge 32.
- Assert rst at RUN cycle 10 of 7×9 → next cycle busy=0, HI=LO=0, state IDLE; a subsequent mflo returns 0.
- Back-to-back multu (6×7 held at input) → second accepted on the edge after DONE, stall high during both RUN and DONE; final LO=42.
- Change dataA/dataB mid-RUN and apply code 6'd32 in IDLE → product uses the latched operands; dataOut=0 and HI/LO unchanged for the non-multiplier code.

Source files
------------

// File: rtl/mips_funct_pkg.sv
// Function codes, ALU operation codes and multiplier state encoding shared by
// the ALU control unit and multu_unit.
package mips_funct_pkg;

    localparam logic [5:0] F_SLL   = 6'd0;
    localparam logic [5:0] F_MFHI  = 6'd16;
    localparam logic [5:0] F_MFLO  = 6'd18;
    localparam logic [5:0] F_MULTU = 6'd25;
    localparam logic [5:0] F_ADD   = 6'd32;
    localparam logic [5:0] F_SUB   = 6'd34;
    localparam logic [5:0] F_AND   = 6'd36;
    localparam logic [5:0] F_OR    = 6'd37;
    localparam logic [5:0] F_SLT   = 6'd42;

    localparam logic [3:0] ALU_AND = 4'b0000;
    localparam logic [3:0] ALU_OR  = 4'b0001;
    localparam logic [3:0] ALU_ADD = 4'b0010;
    localparam logic [3:0] ALU_SUB = 4'b0110;
    localparam logic [3:0] ALU_SLT = 4'b0111;
    localparam logic [3:0] ALU_SLL = 4'b1000;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        RUN  = 2'b01,
        DONE = 2'b10
    } mult_state_e;

endpackage

// File: rtl/multu_unit.sv
// Sequential shift-and-add unsigned multiplier with HI/LO registers serving
// multu, mfhi and mflo; stalls the datapath while a multiply is in flight.
module multu_unit
    import mips_funct_pkg::mult_state_e,
           mips_funct_pkg::IDLE,
           mips_funct_pkg::RUN,
           mips_funct_pkg::DONE;
#(
    parameter int unsigned WIDTH   = 32,
    parameter logic [5:0]  F_MULTU = mips_funct_pkg::F_MULTU,
    parameter logic [5:0]  F_MFHI  = mips_funct_pkg::F_MFHI,
    parameter logic [5:0]  F_MFLO  = mips_funct_pkg::F_MFLO
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [5:0]       SIG_MULTIPLIER,
    input  logic [WIDTH-1:0] dataA,
    input  logic [WIDTH-1:0] dataB,
    output logic [WIDTH-1:0] dataOut,
    output logic             busy,
    output logic             done,
    output logic             stall
);

    localparam int unsigned CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    mult_state_e          state_q, state_d;
    logic [CNT_W-1:0]     count_q, count_d;
    logic [2*WIDTH-1:0]   mcand_q, mcand_d;
    logic [WIDTH-1:0]     mplier_q, mplier_d;
    logic [2*WIDTH-1:0]   prod_q, prod_d;
    logic [WIDTH-1:0]     hi_q, hi_d;
    logic [WIDTH-1:0]     lo_q, lo_d;

    logic                 start;
    logic                 last_iter;
    logic [2*WIDTH-1:0]   acc;

    assign start     = (SIG_MULTIPLIER == F_MULTU);
    assign last_iter = (count_q == CNT_W'(WIDTH - 1));

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= IDLE;
            count_q  <= '0;
            mcand_q  <= '0;
            mplier_q <= '0;
            prod_q   <= '0;
            hi_q     <= '0;
            lo_q     <= '0;
        end else begin
            state_q  <= state_d;
            count_q  <= count_d;
            mcand_q  <= mcand_d;
            mplier_q <= mplier_d;
            prod_q   <= prod_d;
            hi_q     <= hi_d;
            lo_q     <= lo_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (start) state_d = RUN;
            RUN:     if (last_iter) state_d = DONE;
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // The final iteration's sum bypasses prod_q and lands directly in HI/LO.
    always_comb begin
        count_d  = count_q;
        mcand_d  = mcand_q;
        mplier_d = mplier_q;
        prod_d   = prod_q;
        hi_d     = hi_q;
        lo_d     = lo_q;
        acc      = mplier_q[0] ? (prod_q + mcand_q) : prod_q;
        case (state_q)
            IDLE: begin
                if (start) begin
                    mcand_d  = (2*WIDTH)'(dataA);
                    mplier_d = dataB;
                    prod_d   = '0;
                    count_d  = '0;
                end
            end
            RUN: begin
                prod_d   = acc;
                mcand_d  = mcand_q << 1;
                mplier_d = mplier_q >> 1;
                count_d  = count_q + CNT_W'(1);
                if (last_iter) begin
                    {hi_d, lo_d} = acc;
                end
            end
            default: ;
        endcase
    end

    always_comb begin
        busy  = (state_q == RUN) || (state_q == DONE);
        done  = (state_q == DONE);
        stall = busy && ((SIG_MULTIPLIER == F_MULTU) ||
                         (SIG_MULTIPLIER == F_MFHI)  ||
                         (SIG_MULTIPLIER == F_MFLO));
        if (SIG_MULTIPLIER == F_MFHI) begin
            dataOut = hi_q;
        end else if (SIG_MULTIPLIER == F_MFLO) begin
            dataOut = lo_q;
        end else begin
            dataOut = '0;
        end
    end

endmodule

// File: tb/tb_multu_unit.sv
// Directed bench for multu_unit: expected mfhi/mflo results are queued by the
// stimulus and checked by an independent monitor when the read is presented.
module tb_multu_unit;
    import mips_funct_pkg::*;

    localparam logic [5:0] NOP = 6'd0;

    logic        clk = 1'b0;
    logic        rst;
    logic [5:0]  sig;
    logic [31:0] in_a, in_b;
    logic [31:0] dout;
    logic        busy, done, stall;

    multu_unit #(.WIDTH(32)) dut (
        .clk(clk), .rst(rst), .SIG_MULTIPLIER(sig),
        .dataA(in_a), .dataB(in_b), .dataOut(dout),
        .busy(busy), .done(done), .stall(stall)
    );

    always #5 clk = ~clk;

    int tests = 0;
    int fails = 0;

    typedef struct {
        string       name;
        logic [31:0] val;
    } exp_t;
    exp_t exp_q[$];

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
        tests++;
        if (got !== want) begin
            fails++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, got, want);
        end
    endtask

    // Monitor: an unstalled mfhi/mflo is a DUT response; compare against the queue.
    always @(negedge clk) begin
        exp_t e;
        if (rst === 1'b0 && (sig == F_MFHI || sig == F_MFLO) && stall === 1'b0) begin
            if (exp_q.size() == 0) begin
                tests++;
                fails++;
                $display("FAIL unexpected_read: got 0x%08h with no queued expectation", dout);
            end else begin
                e = exp_q.pop_front();
                check(e.name, dout, e.val);
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic rd(input logic [5:0] code, input logic [31:0] v, input string name);
        exp_t e;
        e.name = name;
        e.val  = v;
        exp_q.push_back(e);
        sig = code;
        tick();
        sig = NOP;
    endtask

    task automatic start(input logic [31:0] a, input logic [31:0] b);
        sig  = F_MULTU;
        in_a = a;
        in_b = b;
        tick();
        sig = NOP;
    endtask

    task automatic wait_done(output int nbusy, output int ndone, output int done_at);
        nbusy   = 0;
        ndone   = 0;
        done_at = -1;
        for (int i = 0; i < 60; i++) begin
            @(negedge clk);
            if (!busy) break;
            nbusy++;
            if (done) begin
                ndone++;
                done_at = nbusy;
            end
        end
        tick();
    endtask

    int nb, nd, dat, ns, bad;

    initial begin
        rst  = 1'b1;
        sig  = NOP;
        in_a = '0;
        in_b = '0;
        repeat (2) tick();
        @(negedge clk);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_done", 32'(done), 32'd0);
        check("rst_stall", 32'(stall), 32'd0);
        check("rst_dout", dout, 32'd0);
        rst = 1'b0;
        tick();
        rd(F_MFHI, 32'h0, "rst_hi");
        rd(F_MFLO, 32'h0, "rst_lo");

        // 3 x 5: latency and done pulse position
        start(32'd3, 32'd5);
        wait_done(nb, nd, dat);
        check("busy_cycles", 32'(nb), 32'd33);
        check("done_pulses", 32'(nd), 32'd1);
        check("done_cycle", 32'(dat), 32'd33);
        rd(F_MFHI, 32'h0, "m3x5_hi");
        rd(F_MFLO, 32'hF, "m3x5_lo");

        start(32'hFFFF_FFFF, 32'hFFFF_FFFF);
        wait_done(nb, nd, dat);
        rd(F_MFHI, 32'hFFFF_FFFE, "max_hi");
        rd(F_MFLO, 32'h0000_0001, "max_lo");

        start(32'h8000_0000, 32'd2);
        wait_done(nb, nd, dat);
        rd(F_MFHI, 32'h1, "msb_hi");
        rd(F_MFLO, 32'h0, "msb_lo");

        // establish HI=0x12345678, then read it while stalled during a RUN
        start(32'h2468_ACF0, 32'h8000_0000);
        wait_done(nb, nd, dat);
        rd(F_MFHI, 32'h1234_5678, "prep_hi");
        rd(F_MFLO, 32'h0, "prep_lo");
        start(32'h10, 32'h10);
        repeat (4) tick();
        sig = F_MFHI;
        ns  = 0;
        bad = 0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (done) break;
            ns++;
            if (stall !== 1'b1 || dout !== 32'h1234_5678) bad++;
        end
        check("mfhi_hold_bad", 32'(bad), 32'd0);
        check("mfhi_stall_cycles", 32'(ns), 32'd28);
        check("done_stall", 32'(stall), 32'd1);
        check("done_new_hi", dout, 32'h0);
        tick();
        sig = NOP;
        rd(F_MFLO, 32'h100, "m16_lo");
        rd(F_MFHI, 32'h0, "m16_hi");

        // reset in RUN cycle 10 of 7 x 9
        start(32'd7, 32'd9);
        repeat (9) tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        @(negedge clk);
        check("midrst_busy", 32'(busy), 32'd0);
        check("midrst_done", 32'(done), 32'd0);
        tick();
        rd(F_MFLO, 32'h0, "midrst_lo");
        rd(F_MFHI, 32'h0, "midrst_hi");

        // multu held across a whole multiply and its DONE cycle
        sig  = F_MULTU;
        in_a = 32'd6;
        in_b = 32'd7;
        tick();
        nb = 0;
        ns = 0;
        for (int i = 0; i < 60; i++) begin
            @(negedge clk);
            if (!busy) break;
            nb++;
            if (stall) ns++;
        end
        check("b2b_busy1", 32'(nb), 32'd33);
        check("b2b_stall1", 32'(ns), 32'd33);
        check("b2b_idle_stall", 32'(stall), 32'd0);
        tick();
        sig = NOP;
        wait_done(nb, nd, dat);
        check("b2b_busy2", 32'(nb), 32'd33);
        rd(F_MFLO, 32'd42, "b2b_lo");
        rd(F_MFHI, 32'd0, "b2b_hi");

        // operands changed mid-RUN must not matter; unrelated code is a no-op
        start(32'h1234, 32'h10);
        repeat (3) tick();
        in_a = 32'hFFFF_FFFF;
        in_b = 32'hFFFF_FFFF;
        wait_done(nb, nd, dat);
        check("latched_done", 32'(nd), 32'd1);
        rd(F_MFLO, 32'h12340, "latched_lo");
        rd(F_MFHI, 32'h0, "latched_hi");
        sig = 6'd32;
        @(negedge clk);
        check("other_dout", dout, 32'h0);
        check("other_stall", 32'(stall), 32'd0);
        check("other_busy", 32'(busy), 32'd0);
        tick();
        sig = NOP;
        rd(F_MFHI, 32'h0, "other_hi");
        rd(F_MFLO, 32'h12340, "other_lo");

        tick();
        check("sb_empty", 32'(exp_q.size()), 32'd0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

endmodule
